epu: RTL and testbench
======================

EPU -- requirements
Module: epu

Interface
REQ-001 Parameter VLEN, 256, vector width in bits.
REQ-002 Parameter BSW, 5, log2 of block count; BS = 2^BSW blocks, BLEN = VLEN/BS bits per block, WW = 8-BSW+1 bits per length field.
REQ-003 clk  input  1  clock; all state SHALL update on its rising edge.
REQ-004 rst_n  input  1  asynchronous active-low reset.
REQ-005 in_valid  input  1  input beat valid.
REQ-006 in_ready  output  1  input beat accepted when in_valid && in_ready at clk edge.
REQ-007 in_num  input  BSW+1  number of elements in beat, 0..BS.
REQ-008 in_elen  input  WW  slot width in blocks, 1..2^(WW-1).
REQ-009 in_len  input  WW x BS  kept blocks of element k, entries k < in_num only.
REQ-010 in_data  input  BLEN x BS  aligned blocks; element k occupies blocks k*in_elen .. k*in_elen+in_elen-1.
REQ-011 in_last  input  1  final beat of stream; forces flush.
REQ-012 out_valid  output  1  output word valid.
REQ-013 out_ready  input  1  output word consumed when out_valid && out_ready.
REQ-014 out_data  output  BLEN x BS  packed blocks; unused blocks zero.
REQ-015 out_nblk  output  BSW+1  valid blocks in out_data, 1..BS.
REQ-016 out_last  output  1  final word of stream.
REQ-017 err  output  1  sticky illegal-beat flag.

Function
REQ-018 Packing: kept blocks of element k SHALL be its low min(in_len[k], in_elen) slot blocks (lowest index first), concatenated in element order 0..in_num-1 with no gaps.
REQ-019 Beat block count n = sum of clamped lengths; SHALL be computed at BSW+2 bits without overflow.
REQ-020 Internal buffer of 2*BS blocks with fill counter f (0..BS-1 between words); new blocks SHALL be appended at block index f.
REQ-021 in_ready SHALL be (state == RUN) && (!out_valid || out_ready).
REQ-022 Latency: output word caused by a beat SHALL appear with out_valid=1 on the cycle after acceptance (registered output).
REQ-023 If f+n >= BS: emit low BS blocks, out_nblk=BS; residual f+n-BS blocks SHALL shift to index 0, f <= f+n-BS.
REQ-024 If f+n < BS and !in_last: no output; f <= f+n.
REQ-025 in_last with f+n < BS and f+n > 0: emit one word, out_nblk=f+n, out_last=1, f <= 0.
REQ-026 in_last with f+n == BS: one word, out_nblk=BS, out_last=1, f <= 0.
REQ-027 in_last with f+n > BS: first word out_nblk=BS out_last=0; FSM SHALL enter DRAIN; after that word is consumed, second word out_nblk=f+n-BS out_last=1; return to RUN, f <= 0.
REQ-028 in_last with f+n == 0: no word emitted; state unchanged.
REQ-029 FSM states RUN, DRAIN only; DRAIN SHALL hold in_ready=0.
REQ-030 While out_valid && !out_ready, out_data, out_nblk, out_last SHALL stay stable.
REQ-031 Illegal beat (in_num > BS, in_elen == 0, or in_num*in_elen > BS): SHALL be accepted and dropped, f unchanged, err <= 1.
REQ-032 Blocks at index >= out_nblk in out_data SHALL be zero.

Reset
REQ-033 rst_n low SHALL immediately force out_valid=0, out_last=0, out_nblk=0, out_data=0, err=0, f=0, state=RUN.
REQ-034 in_ready SHALL be 1 on the first cycle after rst_n deasserts; reset mid-stream discards buffer and any DRAIN word.

Verification
REQ-035 Reset: assert rst_n=0 mid-DRAIN -> out_valid=0, err=0, in_ready=1 after release.
REQ-036 BS=32: in_num=32, in_elen=1, all in_len=1, in_data[k]=k -> next cycle out_valid=1, out_data[k]=k, out_nblk=32, out_last=0.
REQ-037 Beat in_num=4, in_elen=8, in_len={2,3,1,4}, then in_last beat with in_num=0 -> one word, out_nblk=10, blocks = src {0,1,8,9,10,16,24,25,26,27}, blocks 10..31 zero, out_last=1.
REQ-038 out_ready=0 held 3 cycles with word pending -> out_data stable, in_ready=0; release -> word consumed once.
REQ-039 f=20, last beat with 16 blocks -> word1 out_nblk=32 out_last=0, in_ready=0 in DRAIN, word2 out_nblk=4 out_last=1.
REQ-040 in_num=5, in_elen=8 -> beat dropped, err=1 until reset, f unchanged.

Source files
------------

// File: rtl/epu.sv
// ---------------------------------------------------------------------------
// epu -- element packing unit
//
// Each input beat carries up to BS elements stored in fixed-width slots of
// in_elen blocks. Element k keeps its low min(in_len[k], in_elen) blocks.
// Kept blocks are appended, with no gaps, to a residual buffer. Full words of
// BS blocks are emitted as they become available. in_last flushes the
// partial remainder as the final word of the stream.
//
// Ports
//   clk, rst_n       clock, asynchronous active-low reset
//   in_valid/ready   input beat handshake
//   in_num           number of elements in the beat (0..BS)
//   in_elen          slot width in blocks
//   in_len           per-element kept-block count, WW bits per element
//   in_data          slot-aligned source blocks, BLEN bits per block
//   in_last          final beat of the stream
//   out_valid/ready  output word handshake
//   out_data         packed blocks; blocks at index >= out_nblk are zero
//   out_nblk         number of valid blocks in out_data
//   out_last         final word of the stream
//   err              sticky flag, set when an illegal beat is dropped
// ---------------------------------------------------------------------------
module epu #(
   parameter int VLEN = 256,
   parameter int BSW  = 5
) (
   input  logic                              clk,
   input  logic                              rst_n,
   input  logic                              in_valid,
   output logic                              in_ready,
   input  logic [BSW:0]                      in_num,
   input  logic [8-BSW:0]                    in_elen,
   input  logic [(8-BSW+1)*(1<<BSW)-1:0]     in_len,
   input  logic [VLEN-1:0]                   in_data,
   input  logic                              in_last,
   output logic                              out_valid,
   input  logic                              out_ready,
   output logic [VLEN-1:0]                   out_data,
   output logic [BSW:0]                      out_nblk,
   output logic                              out_last,
   output logic                              err
);

   localparam int BS   = 1 << BSW;
   localparam int BLEN = VLEN / BS;
   localparam int WW   = 8 - BSW + 1;
   localparam int PW   = BSW + 1 + WW;

   typedef enum logic {RUN = 1'b0, DRAIN = 1'b1} state_t;

   state_t                state_q, state_d;
   logic [BLEN-1:0]       buf_q [BS];
   logic [BLEN-1:0]       buf_d [BS];
   logic [BSW-1:0]        f_q, f_d;
   logic [VLEN-1:0]       odata_q, odata_d;
   logic [BSW:0]          onblk_q, onblk_d;
   logic                  ovalid_q, ovalid_d;
   logic                  olast_q, olast_d;
   logic                  err_q, err_d;

   logic [BLEN-1:0]       din [BS];
   logic [WW-1:0]         clen [BS];
   logic [BLEN-1:0]       cat [2*BS];
   logic [BSW+1:0]        n_beat;
   logic [BSW+1:0]        total;
   logic [PW-1:0]         prod;
   logic                  legal;
   logic                  accept;

   assign in_ready  = (state_q == RUN) && (!ovalid_q || out_ready);
   assign accept    = in_valid && in_ready;
   assign out_valid = ovalid_q;
   assign out_data  = odata_q;
   assign out_nblk  = onblk_q;
   assign out_last  = olast_q;
   assign err       = err_q;

   assign prod  = {{WW{1'b0}}, in_num} * {{(BSW+1){1'b0}}, in_elen};
   assign legal = (in_num <= (BSW+1)'(BS)) && (in_elen != '0) && (prod <= PW'(BS));
   assign total = (BSW+2)'(f_q) + n_beat;

   // Per-element clamped lengths and beat block count (entries k >= in_num ignored)
   always_comb begin
      n_beat = '0;
      for (int k = 0; k < BS; k++) begin
         din[k]  = in_data[k*BLEN +: BLEN];
         clen[k] = '0;
         if (k < int'(in_num)) begin
            clen[k] = (in_len[k*WW +: WW] < in_elen) ? in_len[k*WW +: WW] : in_elen;
         end
         n_beat = n_beat + (BSW+2)'(clen[k]);
      end
   end

   // Residual buffer followed by the newly kept blocks; unwritten entries stay
   // zero, which keeps blocks beyond the fill level zero in every word.
   always_comb begin
      int pos;
      int src;
      pos = int'(f_q);
      src = 0;
      for (int i = 0; i < BS; i++) begin
         cat[i] = buf_q[i];
      end
      for (int i = BS; i < 2*BS; i++) begin
         cat[i] = '0;
      end
      for (int k = 0; k < BS; k++) begin
         for (int j = 0; j < (1 << WW); j++) begin
            if (k < int'(in_num) && j < int'(clen[k])) begin
               src = k * int'(in_elen) + j;
               if (src < BS && pos < 2*BS) begin
                  cat[(BSW+1)'(pos)] = din[BSW'(src)];
               end
               pos = pos + 1;
            end
         end
      end
   end

   // Next-state: word emission, buffer update and RUN/DRAIN control
   always_comb begin
      state_d  = state_q;
      buf_d    = buf_q;
      f_d      = f_q;
      odata_d  = odata_q;
      onblk_d  = onblk_q;
      olast_d  = olast_q;
      ovalid_d = ovalid_q && !out_ready;
      err_d    = err_q;

      if (state_q == DRAIN) begin
         // Remainder of a flush that overflowed one word goes out once the
         // full word ahead of it has been taken.
         if (out_ready) begin
            for (int i = 0; i < BS; i++) begin
               odata_d[i*BLEN +: BLEN] = buf_q[i];
               buf_d[i]                = '0;
            end
            onblk_d  = (BSW+1)'(f_q);
            olast_d  = 1'b1;
            ovalid_d = 1'b1;
            f_d      = '0;
            state_d  = RUN;
         end
      end else if (accept) begin
         if (!legal) begin
            err_d = 1'b1;
         end else if (total >= (BSW+2)'(BS)) begin
            for (int i = 0; i < BS; i++) begin
               odata_d[i*BLEN +: BLEN] = cat[i];
               buf_d[i]                = cat[BS+i];
            end
            onblk_d  = (BSW+1)'(BS);
            ovalid_d = 1'b1;
            f_d      = BSW'(total - (BSW+2)'(BS));
            olast_d  = in_last && (total == (BSW+2)'(BS));
            if (in_last && (total != (BSW+2)'(BS))) begin
               state_d = DRAIN;
            end
         end else if (!in_last) begin
            for (int i = 0; i < BS; i++) begin
               buf_d[i] = cat[i];
            end
            f_d = BSW'(total);
         end else if (total != '0) begin
            for (int i = 0; i < BS; i++) begin
               odata_d[i*BLEN +: BLEN] = cat[i];
               buf_d[i]                = '0;
            end
            onblk_d  = (BSW+1)'(total);
            olast_d  = 1'b1;
            ovalid_d = 1'b1;
            f_d      = '0;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= RUN;
         f_q      <= '0;
         odata_q  <= '0;
         onblk_q  <= '0;
         ovalid_q <= 1'b0;
         olast_q  <= 1'b0;
         err_q    <= 1'b0;
         for (int i = 0; i < BS; i++) begin
            buf_q[i] <= '0;
         end
      end else begin
         state_q  <= state_d;
         f_q      <= f_d;
         odata_q  <= odata_d;
         onblk_q  <= onblk_d;
         ovalid_q <= ovalid_d;
         olast_q  <= olast_d;
         err_q    <= err_d;
         for (int i = 0; i < BS; i++) begin
            buf_q[i] <= buf_d[i];
         end
      end
   end

endmodule

// File: tb/tb_epu.sv
// ---------------------------------------------------------------------------
// tb_epu -- self-checking bench for epu (default VLEN=256, BSW=5).
// A queue-based packing model produces expected words when a beat is
// accepted; a monitor pops and compares them on each output handshake.
// Scenario tasks add direct checks on handshake, latency and flags.
// ---------------------------------------------------------------------------
module tb_epu;

   localparam int BS = 32;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         in_valid = 1'b0;
   logic         in_ready;
   logic [5:0]   in_num = '0;
   logic [3:0]   in_elen = 4'd1;
   logic [127:0] in_len = '0;
   logic [255:0] in_data = '0;
   logic         in_last = 1'b0;
   logic         out_valid;
   logic         out_ready = 1'b1;
   logic [255:0] out_data;
   logic [5:0]   out_nblk;
   logic         out_last;
   logic         err;

   int n_checks = 0;
   int n_fail   = 0;

   typedef struct {
      logic [255:0] data;
      logic [5:0]   nblk;
      logic         last;
   } word_t;

   word_t      exp_q[$];
   logic [7:0] mq[$];
   word_t      mw;

   epu dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_num    (in_num),
      .in_elen   (in_elen),
      .in_len    (in_len),
      .in_data   (in_data),
      .in_last   (in_last),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_nblk  (out_nblk),
      .out_last  (out_last),
      .err       (err)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: time limit reached, expected end of test");
      $fatal(1, "watchdog");
   end

   function automatic logic [255:0] rand256();
      logic [255:0] v;
      for (int i = 0; i < 8; i++) v[i*32 +: 32] = $urandom;
      return v;
   endfunction

   function automatic logic [127:0] rand128();
      logic [127:0] v;
      for (int i = 0; i < 4; i++) v[i*32 +: 32] = $urandom;
      return v;
   endfunction

   // Reference model: flat block queue, words cut from its head
   task automatic model_beat(input int num, input int elen, input logic [127:0] lens,
                             input logic [255:0] data, input bit last);
      word_t w;
      int    cl;
      int    m;
      if (num > BS || elen == 0 || num * elen > BS) return;
      for (int k = 0; k < num; k++) begin
         cl = int'(lens[k*4 +: 4]);
         if (cl > elen) cl = elen;
         for (int j = 0; j < cl; j++) mq.push_back(data[(k*elen + j)*8 +: 8]);
      end
      if (mq.size() >= BS) begin
         w.data = '0;
         for (int i = 0; i < BS; i++) w.data[i*8 +: 8] = mq.pop_front();
         w.nblk = 6'd32;
         w.last = last && (mq.size() == 0);
         exp_q.push_back(w);
      end
      if (last && mq.size() > 0) begin
         m = mq.size();
         w.data = '0;
         for (int i = 0; i < m; i++) w.data[i*8 +: 8] = mq.pop_front();
         w.nblk = 6'(m);
         w.last = 1'b1;
         exp_q.push_back(w);
      end
   endtask

   // Drives one beat from posedge+1, returns at posedge+1 after acceptance
   task automatic send_beat(input int num, input int elen, input logic [127:0] lens,
                            input logic [255:0] data, input bit last);
      bit acc;
      acc      = 1'b0;
      in_valid = 1'b1;
      in_num   = 6'(num);
      in_elen  = 4'(elen);
      in_len   = lens;
      in_data  = data;
      in_last  = last;
      for (int c = 0; c < 50 && !acc; c++) begin
         @(negedge clk);
         if (in_ready) acc = 1'b1;
         @(posedge clk);
         #1;
      end
      in_valid = 1'b0;
      in_last  = 1'b0;
      if (acc) begin
         model_beat(num, elen, lens, data, last);
      end else begin
         n_checks++;
         n_fail++;
         $display("FAIL beat_accept: in_ready stayed %0b for 50 cycles, expected 1", in_ready);
      end
   endtask

   // Scoreboard monitor: compares each word consumed by the handshake
   always @(negedge clk) begin
      if (rst_n && out_valid && out_ready) begin
         n_checks++;
         if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL sb_unexpected: got word nblk=%0d last=%0b, expected no word", out_nblk, out_last);
         end else begin
            mw = exp_q.pop_front();
            if (out_data !== mw.data || out_nblk !== mw.nblk || out_last !== mw.last) begin
               n_fail++;
               $display("FAIL sb_word: got nblk=%0d last=%0b data=%h, expected nblk=%0d last=%0b data=%h",
                        out_nblk, out_last, out_data, mw.nblk, mw.last, mw.data);
            end
         end
      end
   end

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #2;
      n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_valid: got %0b, expected 0", out_valid); end
      n_checks++; if (out_nblk !== 6'd0 || out_last !== 1'b0) begin n_fail++; $display("FAIL rst_nblk_last: got %0d/%0b, expected 0/0", out_nblk, out_last); end
      n_checks++; if (out_data !== '0) begin n_fail++; $display("FAIL rst_data: got %h, expected 0", out_data); end
      n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL rst_err: got %0b, expected 0", err); end
      rst_n = 1'b1;
      @(negedge clk);
      n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL rst_ready: got %0b, expected 1", in_ready); end
      @(posedge clk);
      #1;
   endtask

   task automatic test_full_beat();
      logic [255:0] d;
      for (int k = 0; k < BS; k++) d[k*8 +: 8] = 8'(k);
      out_ready = 1'b1;
      send_beat(32, 1, {32{4'h1}}, d, 1'b0);
      @(negedge clk);
      n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL full_latency: out_valid %0b, expected 1", out_valid); end
      n_checks++; if (out_nblk !== 6'd32 || out_last !== 1'b0) begin n_fail++; $display("FAIL full_nblk: got %0d/%0b, expected 32/0", out_nblk, out_last); end
      n_checks++; if (out_data !== d) begin n_fail++; $display("FAIL full_data: got %h, expected %h", out_data, d); end
      @(posedge clk);
      #1;
   endtask

   task automatic test_pack();
      logic [255:0] d;
      logic [255:0] ev;
      logic [127:0] lens;
      int           srcs [10];
      srcs = '{0, 1, 8, 9, 10, 16, 24, 25, 26, 27};
      for (int k = 0; k < BS; k++) d[k*8 +: 8] = 8'(k);
      lens = rand128();
      lens[15:0] = 16'h4132;
      ev = '0;
      for (int i = 0; i < 10; i++) ev[i*8 +: 8] = 8'(srcs[i]);
      send_beat(4, 8, lens, d, 1'b0);
      @(negedge clk);
      n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL pack_partial: out_valid %0b, expected 0", out_valid); end
      @(posedge clk);
      #1;
      send_beat(0, 8, rand128(), rand256(), 1'b1);
      @(negedge clk);
      n_checks++; if (out_valid !== 1'b1 || out_nblk !== 6'd10 || out_last !== 1'b1) begin n_fail++; $display("FAIL pack_flush: valid/nblk/last %0b/%0d/%0b, expected 1/10/1", out_valid, out_nblk, out_last); end
      n_checks++; if (out_data !== ev) begin n_fail++; $display("FAIL pack_data: got %h, expected %h", out_data, ev); end
      @(posedge clk);
      #1;
   endtask

   task automatic test_backpressure();
      logic [255:0] snap;
      out_ready = 1'b0;
      send_beat(16, 2, {32{4'hF}}, rand256(), 1'b0);
      @(negedge clk);
      snap = out_data;
      n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL bp_valid: got %0b, expected 1", out_valid); end
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         n_checks++; if (out_data !== snap || out_valid !== 1'b1) begin n_fail++; $display("FAIL bp_stable: valid %0b data %h, expected 1 %h", out_valid, out_data, snap); end
         n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_ready: got %0b, expected 0", in_ready); end
      end
      @(posedge clk);
      #1;
      out_ready = 1'b1;
      @(negedge clk);
      @(posedge clk);
      #1;
      @(negedge clk);
      n_checks++; if (out_valid !== 1'b0 || exp_q.size() != 0) begin n_fail++; $display("FAIL bp_once: valid %0b pending %0d, expected 0 0", out_valid, exp_q.size()); end
      @(posedge clk);
      #1;
   endtask

   task automatic test_drain();
      out_ready = 1'b1;
      send_beat(20, 1, {32{4'h1}}, rand256(), 1'b0);
      out_ready = 1'b0;
      send_beat(2, 8, {32{4'h8}}, rand256(), 1'b1);
      @(negedge clk);
      n_checks++; if (out_valid !== 1'b1 || out_nblk !== 6'd32 || out_last !== 1'b0) begin n_fail++; $display("FAIL drain_w1: valid/nblk/last %0b/%0d/%0b, expected 1/32/0", out_valid, out_nblk, out_last); end
      @(posedge clk);
      #1;
      out_ready = 1'b1;
      @(negedge clk);
      n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL drain_ready: got %0b, expected 0", in_ready); end
      @(posedge clk);
      #1;
      @(negedge clk);
      n_checks++; if (out_valid !== 1'b1 || out_nblk !== 6'd4 || out_last !== 1'b1) begin n_fail++; $display("FAIL drain_w2: valid/nblk/last %0b/%0d/%0b, expected 1/4/1", out_valid, out_nblk, out_last); end
      @(posedge clk);
      #1;
   endtask

   task automatic test_illegal();
      out_ready = 1'b1;
      send_beat(3, 1, {32{4'h1}}, rand256(), 1'b0);
      @(negedge clk);
      n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL ill_pre: err %0b, expected 0", err); end
      @(posedge clk);
      #1;
      send_beat(5, 8, {32{4'h8}}, rand256(), 1'b0);
      @(negedge clk);
      n_checks++; if (err !== 1'b1 || out_valid !== 1'b0) begin n_fail++; $display("FAIL ill_drop: err/valid %0b/%0b, expected 1/0", err, out_valid); end
      @(posedge clk);
      #1;
      send_beat(1, 0, {32{4'h1}}, rand256(), 1'b0);
      send_beat(33, 1, {32{4'h1}}, rand256(), 1'b0);
      send_beat(0, 1, '0, rand256(), 1'b1);
      @(negedge clk);
      n_checks++; if (out_nblk !== 6'd3 || out_last !== 1'b1) begin n_fail++; $display("FAIL ill_fill: nblk/last %0d/%0b, expected 3/1", out_nblk, out_last); end
      n_checks++; if (err !== 1'b1) begin n_fail++; $display("FAIL ill_sticky: err %0b, expected 1", err); end
      @(posedge clk);
      #1;
   endtask

   task automatic test_back_to_back();
      int elen;
      int num;
      out_ready = 1'b1;
      for (int b = 0; b < 40; b++) begin
         elen = $urandom_range(1, 8);
         num  = $urandom_range(0, BS / elen);
         send_beat(num, elen, rand128(), rand256(), ($urandom_range(0, 4) == 0));
         out_ready = 1'b0;
         repeat ($urandom_range(0, 2)) begin
            @(posedge clk);
            #1;
         end
         out_ready = 1'b1;
      end
      send_beat(0, 1, '0, rand256(), 1'b1);
      repeat (4) @(posedge clk);
      #1;
      n_checks++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL b2b_drained: %0d words pending, expected 0", exp_q.size()); end
   endtask

   task automatic test_reset_drain();
      out_ready = 1'b1;
      send_beat(20, 1, {32{4'h1}}, rand256(), 1'b0);
      out_ready = 1'b0;
      send_beat(2, 8, {32{4'h8}}, rand256(), 1'b1);
      @(negedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      n_checks++; if (out_valid !== 1'b0 || out_nblk !== 6'd0) begin n_fail++; $display("FAIL rd_valid: valid/nblk %0b/%0d, expected 0/0", out_valid, out_nblk); end
      n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL rd_err: got %0b, expected 0", err); end
      exp_q.delete();
      mq.delete();
      @(posedge clk);
      #2;
      rst_n = 1'b1;
      out_ready = 1'b1;
      @(negedge clk);
      n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL rd_ready: got %0b, expected 1", in_ready); end
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rd_discard: out_valid %0b, expected 0", out_valid); end
      end
      @(posedge clk);
      #1;
   endtask

   initial begin
      test_reset();
      test_full_beat();
      test_pack();
      test_backpressure();
      test_drain();
      test_illegal();
      test_back_to_back();
      test_reset_drain();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
